sync_down_counter: RTL and testbench
====================================

Name: sync_down_counter

Overview:
Parameterised synchronous down counter/timer with a programmable load value, one-shot and auto-reload modes, and a terminal-count pulse. It counts in the opposite direction to the team's 3-bit synchronous up counter. It is the consumer side for count values: load a value N, count to zero, and signal completion. Used as a tick/timeout generator beside the up-counter blocks.

Parameters:
WIDTH, 3, counter and load-value width in bits
PRESCALE, 4, decrement divider ratio (>=2); only used when DOWN_CNT_PRESCALE_EN is defined

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
load  input  1  capture load_val into counter and reload register; abort any run
load_val  input  WIDTH  value to load
start  input  1  begin counting from current count_out
en  input  1  count enable; low holds the count while RUN
auto_reload  input  1  1 = reload on zero and keep running; 0 = one-shot
count_out  output  WIDTH  current count
tc  output  1  terminal-count pulse, one cycle
busy  output  1  high while state is RUN
done  output  1  high while state is DONE

Behaviour:
- Reset (asynchronous, active-high): count_out=0, reload register=0, tc=0, state=IDLE, busy=0, done=0. Reset mid-run aborts immediately, with no tc.
- All outputs are registered. busy = (state==RUN). done = (state==DONE).
- States:
  - IDLE: count held. load updates count and reload. start → RUN.
  - RUN: decrement on each enabled tick (see Optional Feature).
  - DONE: count held at 0. start → RUN, using the current count (0, see zero-start rule). load → IDLE with the new value.
- Priority, highest first: reset > load > start > count.
  - load in any state: count_out=load_val, reload=load_val, tc=0, state=IDLE on the next edge.
  - load and start in the same cycle: load wins and start is ignored.
- start in RUN is ignored.
- RUN with enabled tick:
  - count>1: count-1.
  - count==1: count becomes 0 and tc=1 in the same cycle count_out shows 0. In one-shot mode the state goes to DONE on that edge.
  - count==0 in RUN (auto-reload only): next enabled tick loads the reload value. Auto-reload period is therefore reload+1 ticks, with tc once per period.
- auto_reload is sampled at each zero crossing. If it is deasserted mid-run, the next zero goes to DONE.
- Zero-start: start with count_out==0 produces tc=1 on the next edge. The state then goes to DONE (one-shot) or to RUN with a reload on the next tick (auto).
- Reload value 0 in auto mode: count stays 0 and tc=1 on every enabled tick.
- en=0 in RUN: count and prescaler are held, tc=0, and the state is unchanged.
- tc is never high for two consecutive cycles, except when reload=0 in auto mode.
- Arithmetic: modulo 2^WIDTH. Underflow below 0 never occurs; 0 is the terminal value.

Optional Feature:
- Macro: DOWN_CNT_PRESCALE_EN.
- Defined: an internal prescaler counts enabled cycles. An enabled tick occurs only on every PRESCALE-th enabled cycle in RUN. The prescaler clears on reset, load, and start. Zero-start tc still fires on the next edge, not prescaled.
- Undefined: every cycle with en=1 in RUN is a tick. No prescaler logic is present.

Test Plan (WIDTH=3, macro undefined unless stated):
- Reset mid-run: load 5, start, assert reset after 2 ticks → count_out=0, busy=0, done=0, tc=0 immediately (asynchronous).
- One-shot: load 3, start, en=1 → count_out 3,2,1,0 on successive edges; tc=1 exactly when count_out=0; done=1 from that edge; count held at 0 for 5 further cycles.
- Auto-reload: load 2, auto_reload=1, start → count sequence 2,1,0,2,1,0,…; tc period 3 cycles; busy stays 1.
- Enable gating and priority: load 7, start, toggle en 1,0,0,1 → count 7,6,6,6,5. Then load=1 and start=1 with load_val=4 → count_out=4, state IDLE, start ignored.
- Zero-start and reload 0: load 0, start, auto_reload=0 → tc=1 next edge, done=1. With auto_reload=1 → tc=1 every cycle, count_out=0.
- DOWN_CNT_PRESCALE_EN, PRESCALE=4: load 2, start, en=1 → count decrements every 4th cycle; tc asserted 8 cycles after start.

Source files
------------

// File: rtl/sync_down_counter.sv
// sync_down_counter
// -----------------
// Parameterised synchronous down counter / timer. A value is loaded, the
// counter runs down to zero and pulses tc for one cycle when it gets there.
// In one-shot mode it then parks in DONE. In auto-reload mode it reloads the
// captured value on the following tick and keeps running, giving a period of
// reload+1 ticks.
//
// Optional build macro: DOWN_CNT_PRESCALE_EN
//   When defined, an internal prescaler makes only every PRESCALE-th enabled
//   cycle in RUN a decrement tick. When undefined, every enabled cycle in RUN
//   is a tick and no prescaler logic exists.
//
// Parameters:
//   WIDTH    - counter and load-value width in bits
//   PRESCALE - decrement divider ratio (>=2), used only with the macro
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   load        in   capture load_val into count and reload register, abort run
//   load_val    in   [WIDTH] value to load
//   start       in   begin counting from the current count_out
//   en          in   count enable; low holds the count while running
//   auto_reload in   1 = reload on zero and keep running, 0 = one-shot
//   count_out   out  [WIDTH] current count
//   tc          out  one-cycle terminal-count pulse
//   busy        out  high while in RUN
//   done        out  high while in DONE

module sync_down_counter #(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A divider ratio below 2 would make the prescaler meaningless, so reject
  // it when the design is elaborated rather than producing odd timing.
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("sync_down_counter: PRESCALE must be >= 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             tick;

`ifdef DOWN_CNT_PRESCALE_EN
  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRESC_W-1:0] presc_q, presc_d;

  // The prescaler only advances on enabled cycles in RUN, so a tick is
  // simply the cycle on which it has reached its last value.
  always_comb begin
    tick = (presc_q == PRESC_W'(PRESCALE - 1));
  end

  // Prescaler register, kept apart from the main state so the default
  // build carries no trace of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // Without the prescaler every enabled cycle in RUN decrements.
  always_comb begin
    tick = 1'b1;
  end
`endif

  // Main state register. tc is registered here too so it lines up with the
  // edge on which count_out shows zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic. Priority is load, then start (outside RUN), then
  // counting. tc defaults low so it can only ever be a single-cycle pulse,
  // apart from the reload-of-zero case where every tick is a zero crossing.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
`ifdef DOWN_CNT_PRESCALE_EN
    presc_d  = presc_q;
`endif

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = IDLE;
`ifdef DOWN_CNT_PRESCALE_EN
      presc_d  = '0;
`endif
    end else if (start && (state_q != RUN)) begin
`ifdef DOWN_CNT_PRESCALE_EN
      presc_d = '0;
`endif
      // Starting from zero is already a zero crossing: fire tc at once,
      // then either park or let the next tick fetch the reload value.
      if (count_q == '0) begin
        tc_d    = 1'b1;
        state_d = auto_reload ? RUN : DONE;
      end else begin
        state_d = RUN;
      end
    end else if ((state_q == RUN) && en) begin
`ifdef DOWN_CNT_PRESCALE_EN
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
`endif
      if (tick) begin
        if (count_q == '0) begin
          // Sitting at zero in RUN only happens in auto mode; fetch the
          // reload value. A reload of zero is itself another crossing.
          if (reload_q == '0) begin
            tc_d    = 1'b1;
            state_d = auto_reload ? RUN : DONE;
          end else begin
            count_d = reload_q;
          end
        end else if (count_q == WIDTH'(1)) begin
          count_d = '0;
          tc_d    = 1'b1;
          state_d = auto_reload ? RUN : DONE;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    count_out = count_q;
    tc        = tc_q;
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
  end

endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter
// --------------------
// Directed self-checking bench for sync_down_counter at WIDTH=3. Inputs are
// driven one cycle at a time by applyStimulus; outputs are sampled 1 time
// unit after the rising edge and compared by checkOutput against
// hand-computed values.

module tb_sync_down_counter;

  localparam int WIDTH = 3;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count_out;
  logic             tc;
  logic             busy;
  logic             done;

  int checks;
  int errors;

  sync_down_counter #(
    .WIDTH(WIDTH),
    .PRESCALE(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(load_val),
    .start(start),
    .en(en),
    .auto_reload(auto_reload),
    .count_out(count_out),
    .tc(tc),
    .busy(busy),
    .done(done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic l, input int lv, input logic s,
                               input logic e, input logic a);
    load        = l;
    load_val    = WIDTH'(lv);
    start       = s;
    en          = e;
    auto_reload = a;
    @(posedge clk);
    #1;
  endtask

  // Check all four outputs in one go.
  task automatic checkAll(input string tag, input int c, input int t,
                          input int b, input int d);
    checkOutput({tag, ".count"}, int'(count_out), c);
    checkOutput({tag, ".tc"},    int'(tc),        t);
    checkOutput({tag, ".busy"},  int'(busy),      b);
    checkOutput({tag, ".done"},  int'(done),      d);
  endtask

  initial begin
    int exp_seq [6];
    int exp_tc  [6];

    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    load        = 1'b0;
    load_val    = '0;
    start       = 1'b0;
    en          = 1'b0;
    auto_reload = 1'b0;

    #12;
    checkAll("reset", 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

`ifdef DOWN_CNT_PRESCALE_EN
    // Prescaled run: load 2, decrement every 4th enabled cycle.
    applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
    checkAll("pre_start", 2, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("pre_count%0d", k), int'(count_out),
                  (k < 4) ? 2 : ((k < 8) ? 1 : 0));
      checkOutput($sformatf("pre_tc%0d", k), int'(tc), (k == 8) ? 1 : 0);
    end
    checkOutput("pre_done", int'(done), 1);
`else
    // Reset mid-run: load 5, start, two ticks, then async reset.
    applyStimulus(1'b1, 5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
    checkAll("rst_start", 5, 0, 1, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkAll("rst_run", 3, 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    checkAll("rst_async", 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkAll("rst_after", 0, 0, 0, 0);

    // One-shot from 3.
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0);
    checkAll("os_load", 3, 0, 0, 0);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
    checkAll("os_start", 3, 0, 1, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkAll("os_2", 2, 0, 1, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkAll("os_1", 1, 0, 1, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkAll("os_0", 0, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
      checkAll($sformatf("os_hold%0d", k), 0, 0, 0, 1);
    end

    // Auto-reload from 2: 2,1,0,2,1,0 with tc on each 0.
    applyStimulus(1'b1, 2, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1);
    checkAll("ar_start", 2, 0, 1, 0);
    exp_seq = '{1, 0, 2, 1, 0, 2};
    exp_tc  = '{0, 1, 0, 0, 1, 0};
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
      checkAll($sformatf("ar_%0d", k), exp_seq[k], exp_tc[k], 1, 0);
    end

    // Enable gating, then load+start in the same cycle.
    applyStimulus(1'b1, 7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
    checkAll("en_start", 7, 0, 1, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkAll("en_1", 6, 0, 1, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkAll("en_0a", 6, 0, 1, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkAll("en_0b", 6, 0, 1, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkAll("en_1b", 5, 0, 1, 0);
    applyStimulus(1'b1, 4, 1'b1, 1'b1, 1'b0);
    checkAll("prio_load", 4, 0, 0, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkAll("prio_idle", 4, 0, 0, 0);

    // Zero-start one-shot, then restart from DONE in auto mode (reload 0).
    applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
    checkAll("z_load", 0, 0, 0, 0);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
    checkAll("z_start", 0, 1, 0, 1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkAll("z_hold", 0, 0, 0, 1);
    applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1);
    checkAll("z_auto_start", 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
      checkAll($sformatf("z_auto%0d", k), 0, 1, 1, 0);
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    checkAll("z_auto_en0", 0, 0, 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
